// File: rtl/food_spawner_pkg.sv
// Shared constants, FSM encoding and LFSR step function for the food spawner.
package food_spawner_pkg;

  localparam int unsigned CELL_SHIFT = 4;
  localparam int unsigned CELL_PX    = 1 << CELL_SHIFT;
  localparam int unsigned GRID_W     = 40;
  localparam int unsigned GRID_H     = 30;
  localparam int unsigned SCREEN_W   = GRID_W * CELL_PX;
  localparam int unsigned SCREEN_H   = GRID_H * CELL_PX;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Food cell after reset: pixel (304, 448).
  localparam logic [5:0] RESET_CX = 6'd19;
  localparam logic [4:0] RESET_CY = 5'd28;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_QUERY,
    ST_SCAN_INIT,
    ST_SCAN_Q,
    ST_COMMIT
  } state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift); exposes the bit fields
// used as a candidate grid cell.
module lfsr16 import food_spawner_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [5:0] cand_x_o,
  output logic [4:0] cand_y_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = lfsr_step(lfsr_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign cand_x_o = lfsr_q[5:0];
  assign cand_y_o = lfsr_q[12:8];

endmodule

// File: rtl/food_spawner.sv
// Picks a free grid cell for the next food item on each eat event: random
// LFSR draws checked against snake occupancy, then a row-major scan fallback.
module food_spawner #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned MAX_TRIES = 8,
  parameter int unsigned GRID_W    = food_spawner_pkg::GRID_W,
  parameter int unsigned GRID_H    = food_spawner_pkg::GRID_H
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_eat,
  output logic       o_occ_req,
  output logic [5:0] o_occ_cx,
  output logic [4:0] o_occ_cy,
  input  logic       i_occ_ack,
  input  logic       i_occ_hit,
  output logic [9:0] o_food_x,
  output logic [9:0] o_food_y,
  output logic       o_food_update,
  output logic       o_busy,
  output logic       o_board_full
);

  import food_spawner_pkg::*;

  localparam logic [5:0]  LAST_X    = 6'(GRID_W - 1);
  localparam logic [4:0]  LAST_Y    = 5'(GRID_H - 1);
  localparam logic [10:0] SCAN_LAST = 11'(GRID_W * GRID_H - 1);
  localparam logic [7:0]  TRY_LIMIT = 8'(MAX_TRIES);

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic [7:0]  tries_q, tries_d;
  logic [5:0]  qx_q, qx_d, fx_q, fx_d;
  logic [4:0]  qy_q, qy_d, fy_q, fy_d;
  logic [10:0] cnt_q, cnt_d;
  logic        full_q, full_d;

  logic [5:0]  cand_x;
  logic [4:0]  cand_y;
  logic        cand_bad;
  logic        q_is_food;
  logic [7:0]  tries_inc;
  logic [10:0] cnt_inc;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .cand_x_o (cand_x),
    .cand_y_o (cand_y)
  );

  // Row-major successor, wrapping the last cell back to (0,0); packed {x,y}.
  function automatic logic [10:0] next_cell(input logic [5:0] x, input logic [4:0] y);
    if (x == LAST_X) return {6'd0, (y == LAST_Y) ? 5'd0 : y + 5'd1};
    return {x + 6'd1, y};
  endfunction

  assign cand_bad  = (cand_x > LAST_X) || (cand_y > LAST_Y) ||
                     ((cand_x == fx_q) && (cand_y == fy_q));
  assign q_is_food = (qx_q == fx_q) && (qy_q == fy_q);
  assign tries_inc = tries_q + 8'd1;
  assign cnt_inc   = cnt_q + 11'd1;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    tries_d = tries_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    cnt_d   = cnt_q;
    full_d  = full_q;

    if (state_q != ST_IDLE && i_eat) pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (i_eat || pend_q) begin
          pend_d = 1'b0;
          if (!full_q) begin
            tries_d = '0;
            state_d = ST_DRAW;
          end
        end
      end
      ST_DRAW: begin
        qx_d = cand_x;
        qy_d = cand_y;
        if (cand_bad) begin
          tries_d = tries_inc;
          state_d = (tries_inc == TRY_LIMIT) ? ST_SCAN_INIT : ST_DRAW;
        end else begin
          state_d = ST_QUERY;
        end
      end
      ST_QUERY: begin
        if (i_occ_ack) begin
          if (i_occ_hit) begin
            tries_d = tries_inc;
            state_d = (tries_inc == TRY_LIMIT) ? ST_SCAN_INIT : ST_DRAW;
          end else begin
            fx_d    = qx_q;
            fy_d    = qy_q;
            state_d = ST_COMMIT;
          end
        end
      end
      ST_SCAN_INIT: begin
        {qx_d, qy_d} = next_cell(fx_q, fy_q);
        cnt_d        = '0;
        state_d      = ST_SCAN_Q;
      end
      ST_SCAN_Q: begin
        // The current food cell is stepped over without a query and without counting.
        if (q_is_food) begin
          {qx_d, qy_d} = next_cell(qx_q, qy_q);
        end else if (i_occ_ack) begin
          if (!i_occ_hit) begin
            fx_d    = qx_q;
            fy_d    = qy_q;
            state_d = ST_COMMIT;
          end else if (cnt_inc == SCAN_LAST) begin
            full_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d        = cnt_inc;
            {qx_d, qy_d} = next_cell(qx_q, qy_q);
          end
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Food registers load on entry to COMMIT so the new position appears with the strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      tries_q <= '0;
      qx_q    <= '0;
      qy_q    <= '0;
      fx_q    <= RESET_CX;
      fy_q    <= RESET_CY;
      cnt_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tries_q <= tries_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
    end
  end

  assign o_occ_req     = (state_q == ST_QUERY) || ((state_q == ST_SCAN_Q) && !q_is_food);
  assign o_occ_cx      = qx_q;
  assign o_occ_cy      = qy_q;
  assign o_food_x      = 10'(fx_q) << CELL_SHIFT;
  assign o_food_y      = 10'(fy_q) << CELL_SHIFT;
  assign o_food_update = (state_q == ST_COMMIT);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_board_full  = full_q;

endmodule

// File: doc/food_spawner.md
Name: food_spawner

Overview:
- Upstream stage of the food render object: on each "snake ate" event, picks a new grid-aligned food cell and drives the food position plus a one-cycle update strobe into the renderer's food_x/food_y/ate inputs.
- Free-running LFSR with rejection sampling; candidates are checked against a snake-occupancy query port; linear-scan fallback after repeated rejections.
- Playfield 640x480, 16-px cells = 40x30 cells.

Parameters:
- LFSR_SEED, 16'hACE1, nonzero reset value of the LFSR; a zero value is illegal.
- MAX_TRIES, 8, random rejections allowed before switching to linear scan (range 1..255).
- GRID_W, 40, cells per row.
- GRID_H, 30, cells per column.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_eat  in  1  one-cycle pulse: snake head reached the food.
- o_occ_req  out  1  occupancy query valid; held until acked.
- o_occ_cx  out  6  queried cell x (0..39).
- o_occ_cy  out  5  queried cell y (0..29).
- i_occ_ack  in  1  query response strobe.
- i_occ_hit  in  1  cell occupied by the snake; valid only when i_occ_ack=1.
- o_food_x  out  10  food pixel x = cell_x*16.
- o_food_y  out  10  food pixel y = cell_y*16.
- o_food_update  out  1  one-cycle strobe when o_food_x/o_food_y change; drives the renderer's ate input.
- o_busy  out  1  high in any state other than IDLE.
- o_board_full  out  1  sticky: no free cell was found.

Behaviour:
- Reset (async):
  - LFSR=LFSR_SEED; state=IDLE.
  - Food cell=(19,28), so o_food_x=304 and o_food_y=448.
  - o_food_update=0, o_occ_req=0, o_board_full=0, o_busy=0.
  - Pending flag and try counter cleared.
- LFSR: 16-bit Galois, mask 16'hB400, shifts right every cycle regardless of state.
- Pending latch: i_eat outside IDLE sets a single pending flag (multiple events collapse into one). IDLE treats (i_eat | pending) as a request and clears pending.
- FSM:
  - IDLE: on request, tries=0, go to DRAW. If o_board_full=1, requests are ignored and pending is cleared.
  - DRAW (1 cycle):
    - Candidate cx=lfsr[5:0], cy=lfsr[12:8].
    - If cx>=GRID_W, cy>=GRID_H, or the candidate equals the current food cell: tries+1 and stay in DRAW. Otherwise go to QUERY.
    - When tries reaches MAX_TRIES, go to SCAN_INIT.
  - QUERY: o_occ_req=1 with o_occ_cx/o_occ_cy stable.
    - On i_occ_ack with hit=0: go to COMMIT.
    - On i_occ_ack with hit=1: tries+1, go to DRAW (or SCAN_INIT if tries has reached MAX_TRIES).
    - o_occ_req drops the cycle after the ack.
  - SCAN_INIT: scan cell = current food cell +1 (row-major, wraps (39,29)->(0,0)); scan count=0; go to SCAN_Q.
  - SCAN_Q:
    - Query the scan cell with the same handshake.
    - Skip the current food cell without querying it.
    - hit=0: go to COMMIT.
    - hit=1: advance cell and count. When count reaches GRID_W*GRID_H-1, set o_board_full, go to IDLE, no update.
  - COMMIT (1 cycle): register the new cell into o_food_x/o_food_y (cell<<4, zero-extended to 10 bits), pulse o_food_update=1 for exactly this cycle, go to IDLE.
- Latency: best case with same-cycle ack is i_eat@T, DRAW@T+1, QUERY/ack@T+2, COMMIT with o_food_update high @T+3. New coordinates are visible together with the strobe.
- No timeout on i_occ_ack; the block waits indefinitely.
- Reset asserted mid-search aborts immediately. All outputs return to reset values; the pending event is lost.
- o_food_x/o_food_y change only in COMMIT.

Decomposition:
- Shared package: CELL_PX=16, GRID_W=40, GRID_H=30, screen size, cell-to-pixel shift (4), FSM state encoding, LFSR mask 16'hB400.
- Sub-module lfsr16 (free-running Galois LFSR, seed parameter). The FSM and counters stay in food_spawner.

Test Plan:
- Reset: i_rst_n low 3 cycles -> o_food_x=304, o_food_y=448; o_food_update, o_occ_req, o_busy, o_board_full all 0.
- i_eat pulse, responder acks the same cycle with hit=0 -> o_food_update high exactly at T+3. o_food_x/o_food_y equal 16x the acked o_occ_cx/o_occ_cy, with cx<40 and cy<30.
- Responder with hit=1 for the first 3 queries, then 0 (MAX_TRIES=8) -> three re-draws, one commit, single o_food_update. Queried cells are all in range and differ from the previous food cell.
- MAX_TRIES=1, food at (39,29), responder always hit except cell (1,0) -> scan queries (0,0) then (1,0); commit gives o_food_x=16, o_food_y=0.
- Responder always hit -> after scanning 1199 cells, o_board_full=1, o_food_x/o_food_y unchanged, no o_food_update; a later i_eat is ignored.
- Three i_eat pulses while busy plus ack delays of 5 cycles -> exactly two o_food_update strobes total. Asserting reset mid-QUERY drops o_occ_req asynchronously.
